weight_read_sequencer: RTL

- Controller for the 10-column dual-port weight memory bank (784 x int8 per column, two read ports per column).
- On start: pulses the memories' load phase once after reset (or on request), then sweeps both read ports through all input indices two per cycle (addr1 even, addr2 odd).
- Emits latency-aligned valid/first/last strobes so the downstream MAC array accumulates 10 neuron sums in N_INPUTS/2 issue cycles.
- Sits between the network top-level FSM and the weight memory bank / MAC array.

---
 rtl/wmem_pkg.sv | 17 +
 rtl/strobe_delay.sv | 25 ++
 rtl/weight_read_sequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/wmem_pkg.sv
// Shared constants and FSM state type for the weight memory bank and its read sequencer.
package wmem_pkg;

  localparam int N_INPUTS         = 784;
  localparam int N_COLS           = 10;
  localparam int ADDR_W           = 10;
  localparam int LOAD_ADDR_LENGTH = 9;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/strobe_delay.sv
// Fixed-depth shift register aligning issue strobes with weight memory read latency.
module strobe_delay #(
  parameter int DEPTH = 1,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sr [DEPTH];

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/weight_read_sequencer.sv
// Sequences load phase and paired even/odd read sweeps of the weight memory bank,
// emitting latency-aligned valid/first/last strobes for the MAC array.
module weight_read_sequencer #(
  parameter int N_INPUTS    = wmem_pkg::N_INPUTS,
  parameter int ADDR_W      = wmem_pkg::ADDR_W,
  parameter int RD_LAT      = 1,
  parameter int LOAD_CYCLES = 1 << wmem_pkg::LOAD_ADDR_LENGTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              reload,
  input  logic              hold,
  output logic              load,
  output logic [ADDR_W-1:0] addr1,
  output logic [ADDR_W-1:0] addr2,
  output logic              rd_valid,
  output logic              rd_first,
  output logic              rd_last,
  output logic              busy,
  output logic              done
);

  import wmem_pkg::*;

  localparam int KW  = $clog2(N_INPUTS / 2);
  localparam int LCW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
  localparam logic [KW-1:0]  K_LAST  = KW'(N_INPUTS / 2 - 1);
  localparam logic [LCW-1:0] LC_LAST = LCW'(LOAD_CYCLES - 1);
  localparam logic [1:0]     DC_LAST = 2'(RD_LAT - 1);

  if ((N_INPUTS % 2) != 0 || N_INPUTS < 4) begin : g_bad_n
    $error("weight_read_sequencer: N_INPUTS must be even and >= 4");
  end
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
    $error("weight_read_sequencer: RD_LAT must be in 1..4");
  end

  state_t         state, state_nx;
  logic [KW-1:0]  k;
  logic [LCW-1:0] lc;
  logic [1:0]     dc;
  logic           loaded, reload_pend;
  logic           issue, load_done, drain_done;
  logic [2:0]     strobe_in, strobe_out;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    load       = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    issue      = 1'b0;
    load_done  = 1'b0;
    drain_done = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = (!loaded || reload_pend) ? LOAD : RUN;
      end
      LOAD: begin
        load = 1'b1;
        if (lc == LC_LAST) begin
          load_done = 1'b1;
          state_nx  = RUN;
        end
      end
      RUN: begin
        issue = !hold;
        if (issue && k == K_LAST) state_nx = DRAIN;
      end
      DRAIN: begin
        if (dc == DC_LAST) begin
          drain_done = 1'b1;
          state_nx   = DONE;
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // addr2 reads 0 straight out of reset and is set to 1 when a pass starts;
  // addresses return to (0,1) on entry to DONE so DONE already shows them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      k           <= '0;
      lc          <= '0;
      dc          <= '0;
      addr1       <= '0;
      addr2       <= '0;
      loaded      <= 1'b0;
      reload_pend <= 1'b0;
    end else begin
      if (reload)         reload_pend <= 1'b1;
      else if (load_done) reload_pend <= 1'b0;
      if (load_done) loaded <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            k     <= '0;
            lc    <= '0;
            addr1 <= '0;
            addr2 <= ADDR_W'(1);
          end
        end
        LOAD: begin
          if (!load_done) lc <= lc + 1'b1;
        end
        RUN: begin
          if (issue) begin
            if (k == K_LAST) begin
              dc <= '0;
            end else begin
              k     <= k + 1'b1;
              addr1 <= addr1 + ADDR_W'(2);
              addr2 <= addr2 + ADDR_W'(2);
            end
          end
        end
        DRAIN: begin
          if (drain_done) begin
            k     <= '0;
            addr1 <= '0;
            addr2 <= ADDR_W'(1);
          end else begin
            dc <= dc + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign strobe_in = {issue, issue && (k == '0), issue && (k == K_LAST)};

  strobe_delay #(
    .DEPTH (RD_LAT),
    .W     (3)
  ) u_strobe (
    .clk   (clk),
    .clr_n (rst),
    .d     (strobe_in),
    .q     (strobe_out)
  );

  assign {rd_valid, rd_first, rd_last} = strobe_out;

endmodule
